// File: rtl/adder_bist_4_if.sv
// rtl/adder_bist_4_if.sv - Operand/result bus between the BIST engine and the 4-bit adder under test
interface adder_bist_4_if;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_cin;
  logic [3:0] dut_sum;
  logic       dut_cout;

  modport master (output dut_a, dut_b, dut_cin, input dut_sum, dut_cout);
  modport slave  (input dut_a, dut_b, dut_cin, output dut_sum, dut_cout);
endinterface

// File: rtl/adder_bist_4.sv
// rtl/adder_bist_4.sv - Exhaustive sequential self-test of a 4-bit adder against a golden add
module adder_bist_4 #(
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           start_i,
  input  logic           abort_i,
  adder_bist_4_if.master dut_if,
  output logic           busy_o,
  output logic           done_o,
  output logic           pass_o,
  output logic [9:0]     err_count_o,
  output logic [3:0]     fail_a_o,
  output logic [3:0]     fail_b_o,
  output logic           fail_cin_o,
  output logic [3:0]     fail_sum_o,
  output logic           fail_cout_o,
  output logic           fail_valid_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } fail_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [8:0] VEC_LAST    = 9'h1FF;

  state_e     state_q, state_d;
  logic [8:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] err_q, err_d;
  fail_t      fail_q, fail_d;
  logic       fail_valid_q, fail_valid_d;
  logic [4:0] golden;
  logic       mismatch;

  // The vector index {cin, a, b} doubles as the sweep counter, giving cin-outer / b-inner order.
  assign dut_if.dut_cin = vec_q[8];
  assign dut_if.dut_a   = vec_q[7:4];
  assign dut_if.dut_b   = vec_q[3:0];

  assign golden   = {1'b0, vec_q[7:4]} + {1'b0, vec_q[3:0]} + {4'd0, vec_q[8]};
  assign mismatch = ({dut_if.dut_cout, dut_if.dut_sum} != golden);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_d       = fail_q;
    fail_valid_d = fail_valid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d      = ST_SETTLE;
          vec_d        = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_d       = '0;
          fail_valid_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        // Abort takes precedence, so an aborted final check never reports done.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          if (mismatch) begin
            if (err_q != '1) begin
              err_d = err_q + 10'd1;
            end
            if (!fail_valid_q) begin
              fail_d       = {vec_q[7:4], vec_q[3:0], vec_q[8], dut_if.dut_sum, dut_if.dut_cout};
              fail_valid_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + 9'd1;
            state_d = ST_SETTLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_q       <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_q       <= fail_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign busy_o       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done_o       = (state_q == ST_DONE);
  assign pass_o       = done_o && (err_q == '0);
  assign err_count_o  = err_q;
  assign fail_a_o     = fail_q.a;
  assign fail_b_o     = fail_q.b;
  assign fail_cin_o   = fail_q.cin;
  assign fail_sum_o   = fail_q.sum;
  assign fail_cout_o  = fail_q.cout;
  assign fail_valid_o = fail_valid_q;

endmodule

// File: tb/tb_adder_bist_4.sv
// tb/tb_adder_bist_4.sv - Bench for adder_bist_4: two instances (SETTLE 1 and 3) against a sweep-level model
module tb_adder_bist_4;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   fault_mode = 0;
  logic [4:0] rand_mask [512];
  logic       bad_tab [512];

  adder_bist_4_if bus1 ();
  adder_bist_4_if bus3 ();

  logic [1:0] busy, done, pass, fcin, fcout, fvalid;
  logic [9:0] err [2];
  logic [3:0] fa [2];
  logic [3:0] fb [2];
  logic [3:0] fs [2];
  logic [8:0] dvec [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test, optionally faulty: 1 = sum[0] stuck-at-0, 2 = cout stuck-at-0, 3 = random output corruption
  function automatic logic [4:0] adder_out(int fm, logic [8:0] v, logic [4:0] m);
    logic [4:0] r;
    r = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
    case (fm)
      1: r[0] = 1'b0;
      2: r[4] = 1'b0;
      3: r = r ^ m;
      default: ;
    endcase
    return r;
  endfunction

  assign dvec[0] = {bus1.dut_cin, bus1.dut_a, bus1.dut_b};
  assign dvec[1] = {bus3.dut_cin, bus3.dut_a, bus3.dut_b};
  assign {bus1.dut_cout, bus1.dut_sum} = adder_out(fault_mode, dvec[0], rand_mask[dvec[0]]);
  assign {bus3.dut_cout, bus3.dut_sum} = adder_out(fault_mode, dvec[1], rand_mask[dvec[1]]);

  adder_bist_4 #(.SETTLE(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .dut_if(bus1),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_count_o(err[0]),
    .fail_a_o(fa[0]), .fail_b_o(fb[0]), .fail_cin_o(fcin[0]), .fail_sum_o(fs[0]),
    .fail_cout_o(fcout[0]), .fail_valid_o(fvalid[0]));

  adder_bist_4 #(.SETTLE(3)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .dut_if(bus3),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_count_o(err[1]),
    .fail_a_o(fa[1]), .fail_b_o(fb[1]), .fail_cin_o(fcin[1]), .fail_sum_o(fs[1]),
    .fail_cout_o(fcout[1]), .fail_valid_o(fvalid[1]));

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic set_fault(input int m);
    fault_mode = m;
    for (int n = 0; n < 512; n++) begin
      bad_tab[n] = (int'(adder_out(m, 9'(n), rand_mask[n])) != ((n >> 4) & 15) + (n & 15) + ((n >> 8) & 1));
    end
  endtask

  function automatic int period(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int count_bad(int upto);
    int c = 0;
    for (int n = 0; n < upto; n++) if (bad_tab[n]) c++;
    return c;
  endfunction

  function automatic int first_bad(int upto);
    for (int n = 0; n < upto; n++) if (bad_tab[n]) return n;
    return -1;
  endfunction

  function automatic logic [4:0] out_at(int f);
    if (f < 0) return 5'd0;
    return adder_out(fault_mode, 9'(f), rand_mask[f]);
  endfunction

  // Sweep model: 0 idle, 1 running (k cycles since start accepted), 2 done; results frozen on leaving run
  int         m_st [2];
  int         m_k [2];
  int         fr_err [2];
  int         fr_first [2];
  int         fr_vec [2];
  logic [4:0] fr_out [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] <= 0; m_k[i] <= 0; fr_err[i] <= 0; fr_first[i] <= -1; fr_vec[i] <= 0; fr_out[i] <= 5'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_st[i] != 1) begin
          if (start) begin
            m_st[i] <= 1;
            m_k[i]  <= 0;
          end
        end else if (abort) begin
          m_st[i]     <= 0;
          fr_err[i]   <= count_bad(m_k[i] / period(i));
          fr_first[i] <= first_bad(m_k[i] / period(i));
          fr_out[i]   <= out_at(first_bad(m_k[i] / period(i)));
          fr_vec[i]   <= m_k[i] / period(i);
        end else if (m_k[i] + 1 == 512 * period(i)) begin
          m_st[i]     <= 2;
          m_k[i]      <= m_k[i] + 1;
          fr_err[i]   <= count_bad(512);
          fr_first[i] <= first_bad(512);
          fr_out[i]   <= out_at(first_bad(512));
          fr_vec[i]   <= 511;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  task automatic compare_inst(input int i);
    int v, f, e;
    logic [4:0] fo;
    logic [8:0] fv;
    logic eb, ed;
    if (m_st[i] == 1) begin
      v = m_k[i] / period(i); e = count_bad(v); f = first_bad(v); fo = out_at(f); eb = 1'b1; ed = 1'b0;
    end else begin
      v = fr_vec[i]; e = fr_err[i]; f = fr_first[i]; fo = fr_out[i]; eb = 1'b0; ed = (m_st[i] == 2);
    end
    fv = (f < 0) ? 9'd0 : 9'(f);
    chk("busy", i, 32'(busy[i]), 32'(eb));
    chk("done", i, 32'(done[i]), 32'(ed));
    chk("pass", i, 32'(pass[i]), 32'(ed && e == 0));
    chk("err_count", i, 32'(err[i]), 32'(e));
    chk("fail_valid", i, 32'(fvalid[i]), 32'(f >= 0));
    chk("fail_vector", i, 32'({fa[i], fb[i], fcin[i], fs[i], fcout[i]}),
        (f < 0) ? 32'd0 : 32'({fv[7:4], fv[3:0], fv[8], fo[3:0], fo[4]}));
    chk("dut_vector", i, 32'(dvec[i]), 32'(v));
  endtask

  always @(negedge clk) begin
    compare_inst(0);
    compare_inst(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int c0);
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_both_done(input int bound);
    for (int t = 0; t < bound && done != 2'b11; t++) tick();
    chk("sweep_done", 0, 32'(done), 32'd3);
  endtask

  task automatic check_lit(input string tag, input int e, input logic fvb, input logic [13:0] fb14, input logic p);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_err"}, i, 32'(err[i]), 32'(e));
      chk({tag, "_fvalid"}, i, 32'(fvalid[i]), 32'(fvb));
      chk({tag, "_fail"}, i, 32'({fa[i], fb[i], fcin[i], fs[i], fcout[i]}), 32'(fb14));
      chk({tag, "_pass"}, i, 32'(pass[i]), 32'(p));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_busy"}, i, 32'(busy[i]), 32'd0);
      chk({tag, "_done"}, i, 32'(done[i]), 32'd0);
      chk({tag, "_vec"}, i, 32'(dvec[i]), 32'd0);
    end
    check_lit(tag, 0, 1'b0, 14'd0, 1'b0);
  endtask

  initial begin
    int c0, lat1, lat3, n;
    for (int k = 0; k < 512; k++) rand_mask[k] = 5'd0;
    set_fault(0);
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Clean sweep; a second start while busy must not disturb either latency
    pulse_start(c0);
    lat1 = -1; lat3 = -1;
    for (int t = 0; t < 3000 && lat3 < 0; t++) begin
      start = (cyc - c0 == 100);
      tick();
      if (done[0] && lat1 < 0) lat1 = cyc - c0;
      if (done[1] && lat3 < 0) lat3 = cyc - c0;
    end
    start = 1'b0;
    chk("latency_settle1", 0, 32'(lat1), 32'd1024);
    chk("latency_settle3", 1, 32'(lat3), 32'd2048);
    check_lit("clean", 0, 1'b0, 14'd0, 1'b1);

    set_fault(1);
    pulse_start(c0);
    wait_both_done(2200);
    check_lit("sum0_sa0", 256, 1'b1, {4'd0, 4'd1, 1'b0, 4'd0, 1'b0}, 1'b0);

    set_fault(2);
    pulse_start(c0);
    wait_both_done(2200);
    check_lit("cout_sa0", 256, 1'b1, {4'd1, 4'd15, 1'b0, 4'd0, 1'b0}, 1'b0);

    // Abort mid-sweep, then a fresh full sweep
    set_fault(0);
    pulse_start(c0);
    for (int t = 0; t < 400 && cyc - c0 < 300; t++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 0, 32'(busy), 32'd0);
    chk("abort_done", 0, 32'(done), 32'd0);
    pulse_start(c0);
    wait_both_done(2200);
    check_lit("after_abort", 0, 1'b0, 14'd0, 1'b1);

    // Randomly corrupted adder: full sweep, random abort, then simultaneous start+abort from idle
    for (int k = 0; k < 512; k++)
      rand_mask[k] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    set_fault(3);
    pulse_start(c0);
    wait_both_done(2200);
    pulse_start(c0);
    n = $urandom_range(10, 1500);
    repeat (n) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_beats_abort", 0, 32'(busy), 32'd3);
    wait_both_done(2200);

    // Asynchronous reset mid-sweep, then restart from vector 0
    set_fault(1);
    pulse_start(c0);
    n = $urandom_range(50, 900);
    repeat (n) tick();
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(c0);
    chk("restart_busy", 0, 32'(busy), 32'd3);
    chk("restart_vec0", 0, 32'(dvec[0]), 32'd0);
    chk("restart_vec0", 1, 32'(dvec[1]), 32'd0);
    wait_both_done(2200);
    check_lit("restart_sum0", 256, 1'b1, {4'd0, 4'd1, 1'b0, 4'd0, 1'b0}, 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_bist_4.md
ADDER_BIST_4 -- requirements
Module: adder_bist_4

Purpose: sequential built-in self-test driving a 4-bit adder DUT (a, b, cin -> sum, cout) exhaustively and checking it against an internal golden add.

Interface
REQ-001 Parameter SETTLE, default 1, meaning: cycles each vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin sweep; sampled only in IDLE or DONE.
REQ-005 abort  input  1  terminate a running sweep.
REQ-006 dut_sum  input  4  DUT sum result.
REQ-007 dut_cout  input  1  DUT carry out.
REQ-008 dut_a, dut_b  output  4 each  registered DUT operands.
REQ-009 dut_cin  output  1  registered DUT carry in.
REQ-010 busy  output  1  high in SETTLE and CHECK.
REQ-011 done  output  1  sweep completed; held until next start or reset.
REQ-012 pass  output  1  equals done AND err_count==0.
REQ-013 err_count  output  10  mismatching vectors in current or last sweep.
REQ-014 fail_a, fail_b  output  4 each; fail_cin, fail_cout  output  1 each; fail_sum  output  4: first mismatching vector and DUT response.
REQ-015 fail_valid  output  1  fail_* registers hold a captured mismatch.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-017 IDLE/DONE + start=1: clear err_count, fail_*, fail_valid, done; load a=0,b=0,cin=0 onto dut_*; go SETTLE.
REQ-018 SETTLE SHALL hold dut_* for exactly SETTLE cycles, then go CHECK.
REQ-019 CHECK (one cycle) SHALL compare {dut_cout,dut_sum} against 5-bit golden dut_a+dut_b+dut_cin.
REQ-020 On mismatch: err_count increments; if fail_valid=0, capture dut_a/dut_b/dut_cin/dut_sum/dut_cout into fail_* and set fail_valid.
REQ-021 Vector order: cin outer (0,1), a middle (0..15), b inner (0..15); 512 vectors total.
REQ-022 CHECK on non-final vector: advance to next vector in the same cycle, go SETTLE.
REQ-023 CHECK on final vector (cin=1,a=15,b=15): go DONE, assert done; dut_* hold last vector.
REQ-024 Sweep latency: done rises exactly 512*(SETTLE+1) cycles after the cycle start is accepted.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort while busy: go IDLE next cycle, done=0, err_count and fail_* retained; abort in IDLE/DONE ignored.
REQ-027 abort and start in the same cycle in IDLE/DONE: start wins; abort simultaneous with final CHECK: abort wins, done stays 0.
REQ-028 err_count SHALL not wrap (max 512 fits in 10 bits).

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, err_count=0, fail_*=0, fail_valid=0, regardless of clk.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep; first start after release begins at vector 0.

Verification
REQ-031 Correct adder DUT, SETTLE=1, start pulse -> done after 1024 cycles, pass=1, err_count=0, fail_valid=0.
REQ-032 DUT sum[0] stuck-at-0 -> err_count=256, fail_a=0, fail_b=1, fail_cin=0, fail_sum=0, fail_cout=0, pass=0.
REQ-033 DUT cout stuck-at-0 -> err_count=256, fail_a=1, fail_b=15, fail_cin=0, fail_sum=0, fail_cout=0.
REQ-034 Correct DUT, SETTLE=3, start pulsed again at cycle 100 -> ignored; done after exactly 2048 cycles.
REQ-035 abort at cycle 300 -> busy=0 next cycle, done=0; subsequent start -> full clean sweep, pass=1.
REQ-036 rst_n low mid-sweep, asynchronous to clk -> all outputs zero immediately; restart sweeps from a=0,b=0,cin=0.
